// File: rtl/acc_hex.sv
// acc_hex: frame accumulator for eight 4-bit two's-complement operands.
//
// Sums eight accepted operands into a 6-bit two's-complement running sum.
// After the 8th operand the block holds the result until the consumer
// acknowledges it. Every output comes straight from a flop.
//
// Optional feature: define ACC_HEX_SAT_EN to clamp overflowing additions to
// +31 / -32 instead of wrapping modulo 64. The ports and timing are the same
// in both builds.
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   in4..in1        signed 4-bit operand (in4 = sign, in1 = LSB)
//   valid           operand present this cycle
//   ack             consumer has taken the frame result (honoured only in DONE)
//   s6..s1          6-bit two's-complement running sum (s6 = sign)
//   cnt3..cnt1      operands accepted in the current frame, modulo 8
//   done            frame complete; result held
//   ovf             sticky signed-overflow flag for the current frame
module acc_hex (
  input  logic clk,
  input  logic rst,
  input  logic in4,
  input  logic in3,
  input  logic in2,
  input  logic in1,
  input  logic valid,
  input  logic ack,
  output logic s6,
  output logic s5,
  output logic s4,
  output logic s3,
  output logic s2,
  output logic s1,
  output logic cnt3,
  output logic cnt2,
  output logic cnt1,
  output logic done,
  output logic ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  sum_q, sum_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;

  logic [3:0]  operand;
  logic [5:0]  operand_sx;
  logic [6:0]  add_full;
  logic        add_ovf;
  logic [5:0]  add_res;

  assign operand    = {in4, in3, in2, in1};
  assign operand_sx = {{2{operand[3]}}, operand};

  // One guard bit above the 6-bit sum: the true result lies outside -32..+31
  // exactly when the guard bit disagrees with the 6-bit sign.
  always_comb begin
    add_full = {sum_q[5], sum_q} + {operand_sx[5], operand_sx};
    add_ovf  = add_full[6] ^ add_full[5];
`ifdef ACC_HEX_SAT_EN
    if (add_ovf) begin
      add_res = add_full[6] ? 6'b100000 : 6'b011111;
    end else begin
      add_res = add_full[5:0];
    end
`else
    add_res = add_full[5:0];
`endif
  end

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (valid) begin
          // 0 + operand cannot overflow, so the sign-extended operand is the sum.
          sum_d   = operand_sx;
          cnt_d   = 3'd1;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (valid) begin
          sum_d = add_res;
          ovf_d = ovf_q | add_ovf;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        // Any valid operand here is discarded; ack clears the frame.
        if (ack) begin
          state_d = IDLE;
          sum_d   = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        sum_d   = '0;
        cnt_d   = '0;
        done_d  = 1'b0;
        ovf_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sum_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign {s6, s5, s4, s3, s2, s1} = sum_q;
  assign {cnt3, cnt2, cnt1}       = cnt_q;
  assign done                     = done_q;
  assign ovf                      = ovf_q;

endmodule

// File: tb/tb_acc_hex.sv
// tb_acc_hex: directed self-checking bench for acc_hex.
// Each step drives the inputs, waits for the rising edge, and checks the
// registered outputs 1 ns later against hand-computed constants.
module tb_acc_hex;

  logic clk;
  logic rst;
  logic in4, in3, in2, in1;
  logic valid, ack;
  logic s6, s5, s4, s3, s2, s1;
  logic cnt3, cnt2, cnt1;
  logic done, ovf;

  int tests;
  int fails;

  acc_hex dut (
    .clk   (clk),
    .rst   (rst),
    .in4   (in4),
    .in3   (in3),
    .in2   (in2),
    .in1   (in1),
    .valid (valid),
    .ack   (ack),
    .s6    (s6),
    .s5    (s5),
    .s4    (s4),
    .s3    (s3),
    .s2    (s2),
    .s1    (s1),
    .cnt3  (cnt3),
    .cnt2  (cnt2),
    .cnt1  (cnt1),
    .done  (done),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check6(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one cycle, then check sum, cnt, done, ovf after the edge.
  task automatic step(input string tag, input logic r, input logic v, input logic a,
                      input logic [3:0] x, input logic [5:0] es, input logic [2:0] ec,
                      input logic ed, input logic eo);
    rst   = r;
    valid = v;
    ack   = a;
    {in4, in3, in2, in1} = x;
    @(posedge clk);
    #1;
    check6({tag, ".sum"},  {s6, s5, s4, s3, s2, s1}, es);
    check6({tag, ".cnt"},  {3'b000, cnt3, cnt2, cnt1}, {3'b000, ec});
    check6({tag, ".done"}, {5'b00000, done}, {5'b00000, ed});
    check6({tag, ".ovf"},  {5'b00000, ovf}, {5'b00000, eo});
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1; valid = 1'b0; ack = 1'b0;
    {in4, in3, in2, in1} = 4'h0;

    // Reset, including reset with valid and ack asserted.
    step("rst0", 1, 0, 0, 4'h0, 6'h00, 3'd0, 0, 0);
    step("rst1", 1, 1, 1, 4'h7, 6'h00, 3'd0, 0, 0);
    step("idle_noval", 0, 0, 1, 4'h7, 6'h00, 3'd0, 0, 0);

    // Eight operands of +7.
    step("p7_1", 0, 1, 0, 4'h7, 6'h07, 3'd1, 0, 0);
    step("p7_2", 0, 1, 0, 4'h7, 6'h0e, 3'd2, 0, 0);
    step("p7_3", 0, 1, 0, 4'h7, 6'h15, 3'd3, 0, 0);
    step("p7_4", 0, 1, 0, 4'h7, 6'h1c, 3'd4, 0, 0);
`ifdef ACC_HEX_SAT_EN
    step("p7_5", 0, 1, 0, 4'h7, 6'h1f, 3'd5, 0, 1);
    step("p7_6", 0, 1, 0, 4'h7, 6'h1f, 3'd6, 0, 1);
    step("p7_7", 0, 1, 0, 4'h7, 6'h1f, 3'd7, 0, 1);
    step("p7_8", 0, 1, 0, 4'h7, 6'h1f, 3'd0, 1, 1);
    step("p7_hold", 0, 0, 0, 4'h0, 6'h1f, 3'd0, 1, 1);
`else
    step("p7_5", 0, 1, 0, 4'h7, 6'h23, 3'd5, 0, 1);
    step("p7_6", 0, 1, 0, 4'h7, 6'h2a, 3'd6, 0, 1);
    step("p7_7", 0, 1, 0, 4'h7, 6'h31, 3'd7, 0, 1);
    step("p7_8", 0, 1, 0, 4'h7, 6'h38, 3'd0, 1, 1);
    step("p7_hold", 0, 0, 0, 4'h0, 6'h38, 3'd0, 1, 1);
`endif
    step("p7_ack", 0, 0, 1, 4'h0, 6'h00, 3'd0, 0, 0);

    // Eight operands of -8: negative overflow at the 5th.
    step("m8_1", 0, 1, 0, 4'h8, 6'h38, 3'd1, 0, 0);
    step("m8_2", 0, 1, 0, 4'h8, 6'h30, 3'd2, 0, 0);
    step("m8_3", 0, 1, 0, 4'h8, 6'h28, 3'd3, 0, 0);
    step("m8_4", 0, 1, 0, 4'h8, 6'h20, 3'd4, 0, 0);
`ifdef ACC_HEX_SAT_EN
    step("m8_5", 0, 1, 0, 4'h8, 6'h20, 3'd5, 0, 1);
    step("m8_6", 0, 1, 0, 4'h8, 6'h20, 3'd6, 0, 1);
    step("m8_7", 0, 1, 0, 4'h8, 6'h20, 3'd7, 0, 1);
    step("m8_8", 0, 1, 0, 4'h8, 6'h20, 3'd0, 1, 1);
`else
    step("m8_5", 0, 1, 0, 4'h8, 6'h18, 3'd5, 0, 1);
    step("m8_6", 0, 1, 0, 4'h8, 6'h10, 3'd6, 0, 1);
    step("m8_7", 0, 1, 0, 4'h8, 6'h08, 3'd7, 0, 1);
    step("m8_8", 0, 1, 0, 4'h8, 6'h00, 3'd0, 1, 1);
`endif
    step("m8_ack", 0, 0, 1, 4'h0, 6'h00, 3'd0, 0, 0);

    // Mixed frame with a 3-cycle gap after operand 2 (ack in RUN ignored).
    step("mix_1", 0, 1, 0, 4'h7, 6'h07, 3'd1, 0, 0);
    step("mix_2", 0, 1, 0, 4'h7, 6'h0e, 3'd2, 0, 0);
    step("gap_1", 0, 0, 0, 4'h7, 6'h0e, 3'd2, 0, 0);
    step("gap_2", 0, 0, 1, 4'h7, 6'h0e, 3'd2, 0, 0);
    step("gap_3", 0, 0, 0, 4'h8, 6'h0e, 3'd2, 0, 0);
    step("mix_3", 0, 1, 0, 4'h7, 6'h15, 3'd3, 0, 0);
    step("mix_4", 0, 1, 0, 4'h7, 6'h1c, 3'd4, 0, 0);
    step("mix_5", 0, 1, 0, 4'h8, 6'h14, 3'd5, 0, 0);
    step("mix_6", 0, 1, 0, 4'h8, 6'h0c, 3'd6, 0, 0);
    step("mix_7", 0, 1, 0, 4'h8, 6'h04, 3'd7, 0, 0);
    step("mix_8", 0, 1, 0, 4'h8, 6'h3c, 3'd0, 1, 0);

    // Valid in DONE without ack is discarded.
    step("dn_1", 0, 1, 0, 4'h7, 6'h3c, 3'd0, 1, 0);
    step("dn_2", 0, 1, 0, 4'h7, 6'h3c, 3'd0, 1, 0);
    step("dn_3", 0, 1, 0, 4'h8, 6'h3c, 3'd0, 1, 0);
    step("dn_4", 0, 1, 0, 4'h1, 6'h3c, 3'd0, 1, 0);

    // ack and valid together in DONE: ack wins, operand dropped.
    step("ackval", 0, 1, 1, 4'h7, 6'h00, 3'd0, 0, 0);
    step("post_m3", 0, 1, 0, 4'hd, 6'h3d, 3'd1, 0, 0);
    step("run_ack", 0, 0, 1, 4'h0, 6'h3d, 3'd1, 0, 0);

    // Reset mid-frame after three operands of +5.
    step("r_clr", 1, 0, 0, 4'h0, 6'h00, 3'd0, 0, 0);
    step("p5_1", 0, 1, 0, 4'h5, 6'h05, 3'd1, 0, 0);
    step("p5_2", 0, 1, 0, 4'h5, 6'h0a, 3'd2, 0, 0);
    step("p5_3", 0, 1, 0, 4'h5, 6'h0f, 3'd3, 0, 0);
    step("mid_rst", 1, 1, 1, 4'h5, 6'h00, 3'd0, 0, 0);
    step("idle_chk", 0, 0, 0, 4'h5, 6'h00, 3'd0, 0, 0);
    step("p2_1", 0, 1, 0, 4'h2, 6'h02, 3'd1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net: the sequence above is a few hundred ns long.
  initial begin
    #100000;
    $display("FAIL timeout: observed no completion, expected finish before 100000 ns");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/acc_hex.md
ACC_HEX -- requirements
Module: acc_hex

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The ports SHALL be:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in4,in3,in2,in1  input  1 each  signed two's-complement operand from the negate stage; in4 = MSB/sign, in1 = LSB
- valid  input  1  operand present this cycle
- ack  input  1  consumer has taken the frame result
- s6..s1  output  1 each  6-bit two's-complement running sum; s6 = sign
- cnt3..cnt1  output  1 each  operands accepted in the current frame, modulo 8
- done  output  1  frame complete; result held
- ovf  output  1  sticky signed-overflow flag for the current frame

Function
REQ-003 Each operand SHALL be sign-extended from 4 bits (range -8..+7) to 6 bits before addition.
REQ-004 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-005 IDLE behaviour:
- sum = 0, cnt = 0, done = 0, ovf = 0.
- valid = 1: sum <= sext(in), cnt <= 1, next state RUN.
REQ-006 RUN behaviour:
- valid = 1: sum <= sum + sext(in), cnt <= cnt + 1.
- valid = 0: all registers hold.
REQ-007 Acceptance of the 8th operand of a frame (cnt = 7 before the edge) SHALL:
- move the FSM to DONE,
- set done = 1 on the same edge,
- wrap cnt to 0.
REQ-008 DONE behaviour:
- sum, ovf and cnt hold.
- valid is ignored and the operand is discarded.
- ack = 1: next state IDLE, with sum, cnt, done and ovf cleared on that edge.
REQ-009 If valid and ack are both 1 in DONE, ack SHALL win and the operand SHALL NOT be accepted.
REQ-010 ack SHALL be ignored in IDLE and RUN.
REQ-011 Overflow handling:
- Any addition whose true result lies outside -32..+31 SHALL set ovf.
- ovf is sticky until the frame is cleared (ack in DONE) or reset.
REQ-012 With ACC_HEX_SAT_EN undefined, an overflowing addition SHALL wrap modulo 64.
REQ-013 All outputs SHALL be registered; an accepted operand is visible on s6..s1 one clock edge after valid is sampled, with no combinational input-to-output path.

Reset
REQ-014 rst = 1 at a clock edge SHALL force, regardless of state or any simultaneous valid/ack:
- FSM = IDLE
- s6..s1 = 0, cnt3..cnt1 = 0
- done = 0, ovf = 0
REQ-015 A reset mid-frame SHALL discard the partial frame, and the next accepted operand SHALL start a fresh frame.

Configuration
REQ-016 Macro ACC_HEX_SAT_EN:
- Defined: an overflowing addition SHALL clamp the sum to +31 (011111) on positive overflow or -32 (100000) on negative overflow; ovf is still set.
- Undefined: wrap per REQ-012.
- The macro SHALL NOT change the port list or any timing.

Verification
REQ-017 Wrap mode: eight operands of +7 on consecutive cycles.
- Sum becomes -29 at the 5th operand, with ovf = 1 from that edge.
- Final sum = -8 (111000), ovf = 1, done = 1, cnt = 0.
REQ-018 ACC_HEX_SAT_EN defined, same stimulus as REQ-017:
- Sum clamps at 31 from the 5th operand onward.
- Final sum = 011111, ovf = 1, done = 1.
REQ-019 Mixed frame: operands +7,+7,+7,+7,-8,-8,-8,-8.
- Partial sums: 7, 14, 21, 28, 20, 12, 4, -4.
- Final sum = 111100, ovf = 0, done = 1.
REQ-020 Gaps and DONE hold: frame of REQ-019 with valid deasserted for 3 cycles between operands 2 and 3, then valid held 1 for 4 cycles in DONE without ack.
- Sum and cnt hold during the gap.
- The extra operands are discarded and the result holds.
REQ-021 DONE with ack and valid in the same cycle:
- Next cycle: IDLE, sum = 0, done = 0, ovf = 0.
- The following valid with operand -3 gives sum = 111101, cnt = 1.
REQ-022 Reset mid-frame: rst after 3 operands of +5 (sum = 15).
- Next cycle: sum = 0, cnt = 0, done = 0, state IDLE.
- A subsequent operand of +2 gives sum = 000010, cnt = 1.
